// File: rtl/bsg_fifo_reorder_dispatch_pkg.sv
// Shared types and constants for the reorder-FIFO dispatch stage.
// The entry struct is sized from the default build widths below; the top
// module's parameters default to these same values.
package bsg_fifo_reorder_dispatch_pkg;

   // Log2 that never returns zero, so a one-element space still gets a 1-bit field
   function automatic int unsigned safe_clog2(input int unsigned x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

   localparam int unsigned stats_width_lp = 32;

   localparam int unsigned pkg_width_lp    = 32;
   localparam int unsigned pkg_els_lp      = 16;
   localparam int unsigned pkg_num_dest_lp = 16;
   localparam int unsigned pkg_lg_els_lp   = safe_clog2(pkg_els_lp);
   localparam int unsigned pkg_lg_dest_lp  = safe_clog2(pkg_num_dest_lp);

   typedef enum logic {eEmpty, eFull} hold_state_e;

   typedef struct packed {
      logic [pkg_width_lp-1:0]   data;
      logic [pkg_lg_els_lp-1:0]  id;
      logic [pkg_lg_dest_lp-1:0] dest;
   } dispatch_entry_s;

endpackage

// File: rtl/bsg_dispatch_credit_counter.sv
// Per-destination outstanding-request credit counter.
// Resets full; nonzero_o is registered alongside the count.
module bsg_dispatch_credit_counter
   import bsg_fifo_reorder_dispatch_pkg::*;
#(
   parameter int unsigned max_p = 4,
   localparam int unsigned width_lp = safe_clog2(max_p + 1)
)(
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic dec_i,
   input  logic inc_i,
   output logic nonzero_o
);

   logic [width_lp-1:0] count_r;
   logic [width_lp-1:0] count_n;

   // Up/down step; simultaneous take and return cancel out
   always_comb begin
      count_n = count_r;
      if (inc_i & ~dec_i)
         count_n = count_r + width_lp'(1);
      else if (dec_i & ~inc_i)
         count_n = count_r - width_lp'(1);
   end

   // Count and its nonzero flag, both restored to full credit on reset
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_r   <= width_lp'(max_p);
         nonzero_o <= (max_p != 0);
      end else begin
         count_r   <= count_n;
         nonzero_o <= (count_n != '0);
      end
   end

   // A return while already at full credit means the remote side double-returned
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(inc_i && (count_r == width_lp'(max_p))));

endmodule

// File: rtl/bsg_fifo_reorder_dispatch.sv
// Pairs requests with reorder-FIFO IDs and dispatches them to one of
// num_dest_p targets through a one-entry output register, gated by
// per-destination credits.
// Optional statistics counters: define BSG_FIFO_REORDER_DISPATCH_STATS_EN.
module bsg_fifo_reorder_dispatch
   import bsg_fifo_reorder_dispatch_pkg::*;
#(
   parameter int unsigned width_p        = pkg_width_lp,
   parameter int unsigned els_p          = pkg_els_lp,
   parameter int unsigned num_dest_p     = pkg_num_dest_lp,
   parameter int unsigned dest_credits_p = 4,
   localparam int unsigned lg_els_lp     = safe_clog2(els_p),
   localparam int unsigned lg_dest_lp    = safe_clog2(num_dest_p)
)(
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  req_v_i,
   input  logic [width_p-1:0]    req_data_i,
   input  logic [lg_dest_lp-1:0] req_dest_i,
   output logic                  req_ready_o,
   input  logic                  alloc_v_i,
   input  logic [lg_els_lp-1:0]  alloc_id_i,
   output logic                  alloc_yumi_o,
   output logic [num_dest_p-1:0] dest_v_o,
   output logic [width_p-1:0]    dest_data_o,
   output logic [lg_els_lp-1:0]  dest_id_o,
   input  logic [num_dest_p-1:0] dest_yumi_i,
   input  logic [num_dest_p-1:0] credit_return_i
`ifdef BSG_FIFO_REORDER_DISPATCH_STATS_EN
   ,
   output logic [stats_width_lp-1:0] dispatch_count_o,
   output logic [stats_width_lp-1:0] stall_alloc_count_o,
   output logic [stats_width_lp-1:0] stall_credit_count_o
`endif
);

   hold_state_e     state_r, state_n;
   dispatch_entry_s entry_r, entry_n;
   logic [num_dest_p-1:0] dest_v_n;
   logic [num_dest_p-1:0] credit_nz;
   logic [num_dest_p-1:0] credit_dec;
   logic drain, can_load, credit_ok, accept;

   // Handshake: a new entry may load when the register is empty or draining this cycle
   always_comb begin
      drain        = (state_r == eFull) & dest_yumi_i[entry_r.dest];
      can_load     = (state_r == eEmpty) | drain;
      credit_ok    = (32'(req_dest_i) < num_dest_p) & credit_nz[req_dest_i];
      req_ready_o  = reset_n_i & alloc_v_i & can_load & credit_ok;
      accept       = req_v_i & req_ready_o;
      alloc_yumi_o = accept;
   end

   // Output register next state; one-hot valid is computed at load time
   always_comb begin
      state_n  = state_r;
      entry_n  = entry_r;
      dest_v_n = dest_v_o;
      case (state_r)
         eEmpty:  if (accept) state_n = eFull;
         eFull:   if (drain & ~accept) state_n = eEmpty;
         default: state_n = eEmpty;
      endcase
      if (accept) begin
         entry_n  = '{data: req_data_i, id: alloc_id_i, dest: req_dest_i};
         dest_v_n = num_dest_p'(1) << req_dest_i;
      end else if (drain) begin
         dest_v_n = '0;
      end
   end

   // Output register; reset discards any held request
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r  <= eEmpty;
         entry_r  <= '0;
         dest_v_o <= '0;
      end else begin
         state_r  <= state_n;
         entry_r  <= entry_n;
         dest_v_o <= dest_v_n;
      end
   end

   assign dest_data_o = entry_r.data;
   assign dest_id_o   = entry_r.id;

   // One credit counter per destination; credit is taken when the request loads
   for (genvar d = 0; d < num_dest_p; d++) begin : g_credit
      assign credit_dec[d] = accept & (req_dest_i == lg_dest_lp'(d));
      bsg_dispatch_credit_counter #(.max_p(dest_credits_p)) u_credit (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .dec_i     (credit_dec[d]),
         .inc_i     (credit_return_i[d]),
         .nonzero_o (credit_nz[d])
      );
   end

`ifdef BSG_FIFO_REORDER_DISPATCH_STATS_EN
   // Saturating event counters for dispatches and the two stall causes
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         dispatch_count_o     <= '0;
         stall_alloc_count_o  <= '0;
         stall_credit_count_o <= '0;
      end else begin
         if (drain && (dispatch_count_o != '1))
            dispatch_count_o <= dispatch_count_o + stats_width_lp'(1);
         if (req_v_i && !alloc_v_i && (stall_alloc_count_o != '1))
            stall_alloc_count_o <= stall_alloc_count_o + stats_width_lp'(1);
         if (req_v_i && alloc_v_i && can_load && !credit_ok && (stall_credit_count_o != '1))
            stall_credit_count_o <= stall_credit_count_o + stats_width_lp'(1);
      end
   end
`endif

   // A destination may only consume what it is being offered
   a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      ((dest_yumi_i & ~dest_v_o) == '0));

   // Requests must target an existing destination
   a_dest_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(req_v_i && (32'(req_dest_i) >= num_dest_p)));

endmodule
